// File: rtl/bp_fe_pkg.sv
// bp_fe_pkg: shared front-end types and helpers for the instruction queue and decode
//   bp_fe_iq_entry_s  one queued instruction {pc, instr, compressed, bmeta}
//   bp_fe_is_rvc      halfword starts a 16b compressed instruction
package bp_fe_pkg;
  localparam int bp_fe_vaddr_width_gp = 39;
  localparam int bp_fe_bmeta_width_gp = 64;
  typedef struct packed {
    logic [bp_fe_vaddr_width_gp-1:0] pc;
    logic [31:0]                     instr;
    logic                            compressed;
    logic [bp_fe_bmeta_width_gp-1:0] bmeta;
  } bp_fe_iq_entry_s;
  function automatic logic bp_fe_is_rvc(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction
endpackage

// File: rtl/bp_fe_instr_scan.sv
// bp_fe_instr_scan: splits an assembled fetch packet into 16b/32b instructions
//   pc_i/instr_i/count_i        packet PC, halfwords ([0] lowest), valid halfword count
//   slot_*_o                    k-th instruction of the packet: valid, pc, instr, compressed
//   n_instr_o/hw_used_o         instructions found / halfwords they consume
//   A 32b instruction starting in the last valid halfword is left for the realigner.
module bp_fe_instr_scan
  import bp_fe_pkg::*;
#(
  parameter int vaddr_width_p  = 39,
  parameter int fetch_cinstr_p = 2,
  localparam int cw = $clog2(fetch_cinstr_p+1)
) (
  input  logic [vaddr_width_p-1:0]                pc_i,
  input  logic [fetch_cinstr_p*16-1:0]            instr_i,
  input  logic [cw-1:0]                           count_i,
  output logic [fetch_cinstr_p-1:0]               slot_v_o,
  output logic [fetch_cinstr_p*vaddr_width_p-1:0] slot_pc_o,
  output logic [fetch_cinstr_p*32-1:0]            slot_instr_o,
  output logic [fetch_cinstr_p-1:0]               slot_compressed_o,
  output logic [cw-1:0]                           n_instr_o,
  output logic [cw-1:0]                           hw_used_o
);
  logic [fetch_cinstr_p*16+15:0] hw_ext;
  logic [15:0] lo, hi;
  int hw, n;
  logic stop;
  always_comb begin
    hw_ext = {16'h0, instr_i};
    slot_v_o = '0;
    slot_pc_o = '0;
    slot_instr_o = '0;
    slot_compressed_o = '0;
    lo = '0;
    hi = '0;
    hw = 0;
    n = 0;
    stop = 1'b0;
    for (int k = 0; k < fetch_cinstr_p; k++) begin
      if (!stop && hw < int'(count_i)) begin
        lo = hw_ext[hw*16 +: 16];
        hi = hw_ext[(hw+1)*16 +: 16];
        if (bp_fe_is_rvc(lo) || hw + 1 < int'(count_i)) begin
          slot_v_o[k] = 1'b1;
          slot_pc_o[k*vaddr_width_p +: vaddr_width_p] = pc_i + vaddr_width_p'(2*hw);
          slot_compressed_o[k] = bp_fe_is_rvc(lo);
          slot_instr_o[k*32 +: 32] = bp_fe_is_rvc(lo) ? {16'h0, lo} : {hi, lo};
          hw = hw + (bp_fe_is_rvc(lo) ? 1 : 2);
          n = n + 1;
        end else begin
          stop = 1'b1;
        end
      end
    end
    n_instr_o = cw'(n);
    hw_used_o = cw'(hw);
  end
endmodule

// File: rtl/bp_fe_instr_queue.sv
// bp_fe_instr_queue: splits realigned fetch packets into instructions and buffers them for the BE
//   clk_i, reset_n_i (sync, active low)
//   assembled_*_i / assembled_count_o, assembled_yumi_o : packet in, all-or-nothing accept
//   flush_i : empties the queue next cycle, drops the same-cycle packet
//   deq_*_o / deq_yumi_i : one instruction per cycle out
//   BP_FE_IQ_BYPASS_EN : when defined, an accepted packet into an empty queue shows
//   instruction 0 on deq_* in the same cycle; otherwise deq_* comes only from storage.
module bp_fe_instr_queue
  import bp_fe_pkg::*;
#(
  parameter int vaddr_width_p  = bp_fe_vaddr_width_gp,
  parameter int fetch_cinstr_p = 2,
  parameter int bmeta_width_p  = bp_fe_bmeta_width_gp,
  parameter int els_p          = 4,
  localparam int cw = $clog2(fetch_cinstr_p+1)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         assembled_v_i,
  input  logic [vaddr_width_p-1:0]     assembled_pc_i,
  input  logic [fetch_cinstr_p*16-1:0] assembled_instr_i,
  input  logic [bmeta_width_p-1:0]     assembled_bmeta_i,
  input  logic [cw-1:0]                assembled_count_i,
  output logic [cw-1:0]                assembled_count_o,
  output logic                         assembled_yumi_o,
  input  logic                         flush_i,
  output logic                         deq_v_o,
  output logic [31:0]                  deq_instr_o,
  output logic [vaddr_width_p-1:0]     deq_pc_o,
  output logic                         deq_compressed_o,
  output logic [bmeta_width_p-1:0]     deq_bmeta_o,
  input  logic                         deq_yumi_i
);
  localparam int pw = $clog2(els_p);
  localparam int ow = $clog2(els_p+1);
  logic [fetch_cinstr_p-1:0]               slot_v, slot_c, slot_v_sh, slot_c_sh;
  logic [fetch_cinstr_p*vaddr_width_p-1:0] slot_pc, slot_pc_sh;
  logic [fetch_cinstr_p*32-1:0]            slot_instr, slot_instr_sh;
  logic [cw-1:0] n_instr, hw_used, n_wr;
  logic [pw-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [ow-1:0] occ_q, occ_d, free;
  logic byp, skip, deq_fire;
  bp_fe_iq_entry_s head;
  bp_fe_iq_entry_s mem_q [els_p];
  bp_fe_iq_entry_s mem_d [els_p];
  bp_fe_instr_scan #(.vaddr_width_p(vaddr_width_p), .fetch_cinstr_p(fetch_cinstr_p)) scan (
    .pc_i(assembled_pc_i), .instr_i(assembled_instr_i), .count_i(assembled_count_i),
    .slot_v_o(slot_v), .slot_pc_o(slot_pc), .slot_instr_o(slot_instr),
    .slot_compressed_o(slot_c), .n_instr_o(n_instr), .hw_used_o(hw_used)
  );
  always_comb begin
    free = ow'(els_p) - occ_q;
    assembled_yumi_o = reset_n_i & assembled_v_i & ~flush_i & (n_instr != '0)
                     & (int'(free) >= int'(n_instr));
    assembled_count_o = assembled_yumi_o ? hw_used : '0;
`ifdef BP_FE_IQ_BYPASS_EN
    byp = assembled_yumi_o & (occ_q == '0);
`else
    byp = 1'b0;
`endif
    deq_v_o = reset_n_i & ((occ_q != '0) | byp);
    head = byp ? '{slot_pc[vaddr_width_p-1:0], slot_instr[31:0], slot_c[0], assembled_bmeta_i}
               : mem_q[rptr_q];
    deq_instr_o = head.instr;
    deq_pc_o = head.pc;
    deq_compressed_o = head.compressed;
    deq_bmeta_o = head.bmeta;
    // a bypassed instruction taken this cycle is never stored, so shift it out of the write set
    skip = byp & deq_yumi_i;
    slot_v_sh = skip ? slot_v >> 1 : slot_v;
    slot_c_sh = skip ? slot_c >> 1 : slot_c;
    slot_pc_sh = skip ? slot_pc >> vaddr_width_p : slot_pc;
    slot_instr_sh = skip ? slot_instr >> 32 : slot_instr;
    n_wr = assembled_yumi_o ? n_instr - cw'(skip) : '0;
    deq_fire = deq_yumi_i & deq_v_o & ~flush_i & ~byp;
    mem_d = mem_q;
    for (int k = 0; k < fetch_cinstr_p; k++)
      if (assembled_yumi_o && slot_v_sh[k])
        mem_d[pw'(wptr_q + pw'(k))] = '{slot_pc_sh[k*vaddr_width_p +: vaddr_width_p],
                                        slot_instr_sh[k*32 +: 32], slot_c_sh[k], assembled_bmeta_i};
    wptr_d = flush_i ? '0 : wptr_q + pw'(n_wr);
    rptr_d = flush_i ? '0 : rptr_q + pw'(deq_fire);
    occ_d = flush_i ? '0 : occ_q + ow'(n_wr) - ow'(deq_fire);
  end
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
      occ_q <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      occ_q <= occ_d;
    end
    mem_q <= mem_d;
  end
  always_ff @(posedge clk_i)
    if (reset_n_i && deq_yumi_i) assert (deq_v_o);
endmodule

// File: tb/tb_bp_fe_instr_queue.sv
// tb_bp_fe_instr_queue: directed and randomized checks of the instruction queue against a queue model
module tb_bp_fe_instr_queue;
  localparam int vw = 39;
  localparam int bw = 64;
  localparam int els = 4;
`ifdef BP_FE_IQ_BYPASS_EN
  localparam bit byp_en = 1'b1;
`else
  localparam bit byp_en = 1'b0;
`endif
  logic clk_i = 1'b0;
  logic reset_n_i, assembled_v_i, assembled_yumi_o, flush_i, deq_v_o, deq_compressed_o, deq_yumi_i;
  logic [vw-1:0] assembled_pc_i, deq_pc_o;
  logic [31:0] assembled_instr_i, deq_instr_o;
  logic [bw-1:0] assembled_bmeta_i, deq_bmeta_o;
  logic [1:0] assembled_count_i, assembled_count_o;
  int n_checks = 0;
  int n_errors = 0;
  typedef struct {logic [vw-1:0] pc; logic [31:0] instr; logic c; logic [bw-1:0] bmeta;} ent_t;
  ent_t model_q[$];
  ent_t pkt_q[$];
  int pkt_used;

  bp_fe_instr_queue dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .assembled_v_i(assembled_v_i),
    .assembled_pc_i(assembled_pc_i), .assembled_instr_i(assembled_instr_i),
    .assembled_bmeta_i(assembled_bmeta_i), .assembled_count_i(assembled_count_i),
    .assembled_count_o(assembled_count_o), .assembled_yumi_o(assembled_yumi_o),
    .flush_i(flush_i), .deq_v_o(deq_v_o), .deq_instr_o(deq_instr_o), .deq_pc_o(deq_pc_o),
    .deq_compressed_o(deq_compressed_o), .deq_bmeta_o(deq_bmeta_o), .deq_yumi_i(deq_yumi_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic drive(input logic v, input logic [vw-1:0] pc, input logic [31:0] hws,
                       input logic [1:0] cnt, input logic [bw-1:0] bm, input logic dq, input logic fl);
    assembled_v_i = v;
    assembled_pc_i = pc;
    assembled_instr_i = hws;
    assembled_count_i = cnt;
    assembled_bmeta_i = bm;
    deq_yumi_i = dq;
    flush_i = fl;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    drive(0, '0, '0, 0, '0, 0, 0);
    repeat (2) tick();
    reset_n_i = 1'b1;
  endtask

  // packet split derived directly from the halfword rules: 16b unless low bits are 11
  task automatic build_pkt(input logic [vw-1:0] pc, input logic [31:0] hws, input int cnt,
                           input logic [bw-1:0] bm);
    logic [15:0] h [2];
    int off;
    ent_t e;
    h[0] = hws[15:0];
    h[1] = hws[31:16];
    off = 0;
    pkt_q.delete();
    while (off < cnt) begin
      e.pc = pc + vw'(2*off);
      e.bmeta = bm;
      if (h[off][1:0] != 2'b11) begin
        e.instr = {16'h0, h[off]};
        e.c = 1'b1;
        off += 1;
      end else if (off + 1 < cnt) begin
        e.instr = {h[off+1], h[off]};
        e.c = 1'b0;
        off += 2;
      end else break;
      pkt_q.push_back(e);
    end
    pkt_used = off;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    drive(1, 39'h1000, 32'h0001_4501, 2, '0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (deq_v_o !== 1'b0) begin n_errors++; $display("FAIL reset_deq_v: got %b want 0", deq_v_o); end
      n_checks++; if (assembled_yumi_o !== 1'b0) begin n_errors++; $display("FAIL reset_yumi: got %b want 0", assembled_yumi_o); end
      n_checks++; if (assembled_count_o !== 2'd0) begin n_errors++; $display("FAIL reset_count: got %0d want 0", assembled_count_o); end
    end
    reset_n_i = 1'b1;
    drive(0, '0, '0, 0, '0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if (deq_v_o !== 1'b0) begin n_errors++; $display("FAIL idle_deq_v: got %b want 0", deq_v_o); end
      n_checks++; if (assembled_yumi_o !== 1'b0) begin n_errors++; $display("FAIL idle_yumi: got %b want 0", assembled_yumi_o); end
      tick();
    end
  endtask

  task automatic test_basic();
    do_reset();
    drive(1, 39'h1000, {16'h0001, 16'h4501}, 2, 64'hAAAA_5555_1234_0001, 0, 0);
    #1;
    n_checks++; if (assembled_yumi_o !== 1'b1) begin n_errors++; $display("FAIL basic_yumi: got %b want 1", assembled_yumi_o); end
    n_checks++; if (assembled_count_o !== 2'd2) begin n_errors++; $display("FAIL basic_count: got %0d want 2", assembled_count_o); end
    if (!byp_en) begin
      n_checks++; if (deq_v_o !== 1'b0) begin n_errors++; $display("FAIL basic_latency: got %b want 0", deq_v_o); end
    end
    tick();
    drive(0, '0, '0, 0, '0, 1, 0);
    #1;
    n_checks++; if (deq_v_o !== 1'b1) begin n_errors++; $display("FAIL basic_v0: got %b want 1", deq_v_o); end
    n_checks++; if (deq_instr_o !== 32'h0000_4501) begin n_errors++; $display("FAIL basic_instr0: got %h want 00004501", deq_instr_o); end
    n_checks++; if (deq_pc_o !== 39'h1000) begin n_errors++; $display("FAIL basic_pc0: got %h want 1000", deq_pc_o); end
    n_checks++; if (deq_compressed_o !== 1'b1) begin n_errors++; $display("FAIL basic_c0: got %b want 1", deq_compressed_o); end
    n_checks++; if (deq_bmeta_o !== 64'hAAAA_5555_1234_0001) begin n_errors++; $display("FAIL basic_bmeta: got %h", deq_bmeta_o); end
    tick();
    n_checks++; if (deq_instr_o !== 32'h0000_0001) begin n_errors++; $display("FAIL basic_instr1: got %h want 00000001", deq_instr_o); end
    n_checks++; if (deq_pc_o !== 39'h1002) begin n_errors++; $display("FAIL basic_pc1: got %h want 1002", deq_pc_o); end
    tick();
    drive(0, '0, '0, 0, '0, 0, 0);
    #1;
    n_checks++; if (deq_v_o !== 1'b0) begin n_errors++; $display("FAIL basic_empty: got %b want 0", deq_v_o); end
  endtask

  task automatic test_leftover();
    do_reset();
    drive(1, 39'h2000, {16'h0003, 16'h0001}, 2, '0, 0, 0);
    #1;
    n_checks++; if (assembled_yumi_o !== 1'b1) begin n_errors++; $display("FAIL left_yumi: got %b want 1", assembled_yumi_o); end
    n_checks++; if (assembled_count_o !== 2'd1) begin n_errors++; $display("FAIL left_count: got %0d want 1", assembled_count_o); end
    tick();
    drive(0, '0, '0, 0, '0, 1, 0);
    #1;
    n_checks++; if (deq_instr_o !== 32'h1 || deq_pc_o !== 39'h2000) begin n_errors++; $display("FAIL left_head: got %h@%h want 00000001@2000", deq_instr_o, deq_pc_o); end
    tick();
    drive(1, 39'h2100, {16'h0000, 16'h0013}, 1, '0, 0, 0);
    #1;
    n_checks++; if (deq_v_o !== 1'b0) begin n_errors++; $display("FAIL left_single: got deq_v %b want 0", deq_v_o); end
    n_checks++; if (assembled_yumi_o !== 1'b0) begin n_errors++; $display("FAIL left_partial_yumi: got %b want 0", assembled_yumi_o); end
    drive(1, 39'h2100, {16'h0001, 16'h0001}, 0, '0, 0, 0);
    #1;
    n_checks++; if (assembled_yumi_o !== 1'b0 || assembled_count_o !== 2'd0) begin n_errors++; $display("FAIL left_count0: got yumi %b count %0d want 0 0", assembled_yumi_o, assembled_count_o); end
    drive(1, 39'h2200, {16'h1234, 16'h5677}, 2, '0, 0, 0);
    #1;
    n_checks++; if (assembled_yumi_o !== 1'b1 || assembled_count_o !== 2'd2) begin n_errors++; $display("FAIL wide_accept: got yumi %b count %0d want 1 2", assembled_yumi_o, assembled_count_o); end
    tick();
    drive(0, '0, '0, 0, '0, 1, 0);
    #1;
    n_checks++; if (deq_instr_o !== 32'h1234_5677 || deq_compressed_o !== 1'b0 || deq_pc_o !== 39'h2200) begin n_errors++; $display("FAIL wide_head: got %h c=%b @%h want 12345677 c=0 @2200", deq_instr_o, deq_compressed_o, deq_pc_o); end
    tick();
    drive(0, '0, '0, 0, '0, 0, 0);
  endtask

  task automatic test_full();
    logic [vw-1:0] pcs [4];
    logic [31:0] ins [4];
    pcs = '{39'h102, 39'h104, 39'h106, 39'h200};
    ins = '{32'h5, 32'h9, 32'hd, 32'h11};
    do_reset();
    drive(1, 39'h100, {16'h0005, 16'h0001}, 2, '0, 0, 0);
    tick();
    drive(1, 39'h104, {16'h000d, 16'h0009}, 2, '0, 0, 0);
    tick();
    drive(1, 39'h200, {16'h0000, 16'h0011}, 1, '0, 0, 0);
    #1;
    n_checks++; if (assembled_yumi_o !== 1'b0) begin n_errors++; $display("FAIL full_yumi: got %b want 0", assembled_yumi_o); end
    tick();
    drive(1, 39'h200, {16'h0000, 16'h0011}, 1, '0, 1, 0);
    #1;
    n_checks++; if (assembled_yumi_o !== 1'b0) begin n_errors++; $display("FAIL full_deq_same_cycle: got %b want 0", assembled_yumi_o); end
    n_checks++; if (deq_pc_o !== 39'h100) begin n_errors++; $display("FAIL full_head: got %h want 100", deq_pc_o); end
    tick();
    drive(1, 39'h200, {16'h0000, 16'h0011}, 1, '0, 0, 0);
    #1;
    n_checks++; if (assembled_yumi_o !== 1'b1) begin n_errors++; $display("FAIL full_next_yumi: got %b want 1", assembled_yumi_o); end
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, '0, '0, 0, '0, 1, 0);
      #1;
      n_checks++; if (deq_v_o !== 1'b1 || deq_pc_o !== pcs[i] || deq_instr_o !== ins[i]) begin n_errors++; $display("FAIL full_order%0d: got v=%b %h@%h want 1 %h@%h", i, deq_v_o, deq_instr_o, deq_pc_o, ins[i], pcs[i]); end
      tick();
    end
    drive(0, '0, '0, 0, '0, 0, 0);
    #1;
    n_checks++; if (deq_v_o !== 1'b0) begin n_errors++; $display("FAIL full_drained: got %b want 0", deq_v_o); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1, 39'h300, {16'h0005, 16'h0001}, 2, '0, 0, 0);
    tick();
    drive(1, 39'h304, {16'h0000, 16'h0009}, 1, '0, 0, 0);
    tick();
    drive(1, 39'h400, {16'h0005, 16'h0001}, 2, '0, 1, 1);
    #1;
    n_checks++; if (assembled_yumi_o !== 1'b0) begin n_errors++; $display("FAIL flush_yumi: got %b want 0", assembled_yumi_o); end
    n_checks++; if (deq_v_o !== 1'b1 || deq_pc_o !== 39'h300) begin n_errors++; $display("FAIL flush_prehead: got v=%b pc=%h want 1 300", deq_v_o, deq_pc_o); end
    tick();
    drive(0, '0, '0, 0, '0, 0, 0);
    #1;
    n_checks++; if (deq_v_o !== 1'b0) begin n_errors++; $display("FAIL flush_empty: got %b want 0", deq_v_o); end
    drive(1, 39'h500, {16'h0000, 16'h0021}, 1, '0, 0, 0);
    tick();
    drive(0, '0, '0, 0, '0, 1, 0);
    #1;
    n_checks++; if (deq_v_o !== 1'b1 || deq_pc_o !== 39'h500 || deq_instr_o !== 32'h21) begin n_errors++; $display("FAIL flush_refill: got v=%b %h@%h want 1 00000021@500", deq_v_o, deq_instr_o, deq_pc_o); end
    tick();
    drive(0, '0, '0, 0, '0, 0, 0);
    #1;
    n_checks++; if (deq_v_o !== 1'b0) begin n_errors++; $display("FAIL flush_refill_drain: got %b want 0", deq_v_o); end
  endtask

`ifdef BP_FE_IQ_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    drive(1, 39'h3000, {16'h0000, 16'h4501}, 1, 64'h77, 1, 0);
    #1;
    n_checks++; if (deq_v_o !== 1'b1 || deq_instr_o !== 32'h4501 || deq_pc_o !== 39'h3000) begin n_errors++; $display("FAIL bypass_head: got v=%b %h@%h want 1 00004501@3000", deq_v_o, deq_instr_o, deq_pc_o); end
    n_checks++; if (assembled_yumi_o !== 1'b1) begin n_errors++; $display("FAIL bypass_yumi: got %b want 1", assembled_yumi_o); end
    tick();
    drive(0, '0, '0, 0, '0, 0, 0);
    #1;
    n_checks++; if (deq_v_o !== 1'b0) begin n_errors++; $display("FAIL bypass_occ: got %b want 0", deq_v_o); end
  endtask
`endif

  task automatic test_random();
    logic v, fl, dq, exp_yumi, exp_v;
    logic [15:0] h0, h1;
    logic [vw-1:0] pc;
    logic [bw-1:0] bm;
    int cnt, accepted;
    ent_t head;
    do_reset();
    model_q.delete();
    accepted = 0;
    for (int i = 0; i < 300; i++) begin
      v = $urandom_range(0, 3) != 0;
      cnt = $urandom_range(0, 2);
      h0 = 16'($urandom);
      h1 = 16'($urandom);
      if ($urandom_range(0, 1) == 1) h0[1:0] = 2'b11;
      if ($urandom_range(0, 1) == 1) h1[1:0] = 2'b11;
      pc = ($urandom_range(0, 7) == 0) ? {{(vw-1){1'b1}}, 1'b0} : vw'({$urandom, $urandom});
      bm = {$urandom, $urandom};
      fl = $urandom_range(0, 19) == 0;
      build_pkt(pc, {h1, h0}, cnt, bm);
      exp_yumi = v && !fl && pkt_q.size() > 0 && (els - model_q.size() >= pkt_q.size());
      exp_v = model_q.size() > 0 || (byp_en && exp_yumi);
      head = model_q.size() > 0 ? model_q[0] : (exp_v ? pkt_q[0] : head);
      dq = exp_v && $urandom_range(0, 1) == 1;
      drive(v, pc, {h1, h0}, 2'(cnt), bm, dq, fl);
      #1;
      n_checks++; if (deq_v_o !== exp_v) begin n_errors++; $display("FAIL rand_deq_v[%0d]: got %b want %b", i, deq_v_o, exp_v); end
      n_checks++; if (assembled_yumi_o !== exp_yumi) begin n_errors++; $display("FAIL rand_yumi[%0d]: got %b want %b", i, assembled_yumi_o, exp_yumi); end
      n_checks++; if (assembled_count_o !== (exp_yumi ? 2'(pkt_used) : 2'd0)) begin n_errors++; $display("FAIL rand_count[%0d]: got %0d want %0d", i, assembled_count_o, exp_yumi ? pkt_used : 0); end
      if (exp_v) begin
        n_checks++;
        if (deq_instr_o !== head.instr || deq_pc_o !== head.pc || deq_compressed_o !== head.c || deq_bmeta_o !== head.bmeta) begin
          n_errors++;
          $display("FAIL rand_head[%0d]: got %h@%h c=%b m=%h want %h@%h c=%b m=%h", i, deq_instr_o, deq_pc_o, deq_compressed_o, deq_bmeta_o, head.instr, head.pc, head.c, head.bmeta);
        end
      end
      if (fl) model_q.delete();
      else begin
        if (exp_yumi) begin
          foreach (pkt_q[j]) model_q.push_back(pkt_q[j]);
          accepted++;
        end
        if (dq) void'(model_q.pop_front());
      end
      tick();
    end
    drive(0, '0, '0, 0, '0, 0, 0);
    n_checks++; if (accepted < 20) begin n_errors++; $display("FAIL rand_coverage: got %0d accepted packets want >= 20", accepted); end
  endtask

  initial begin
    drive(0, '0, '0, 0, '0, 0, 0);
    test_reset();
    test_basic();
    test_leftover();
    test_full();
    test_flush();
`ifdef BP_FE_IQ_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
